// File: rtl/outport_rr_arbiter.sv
// Output-port arbiter: picks one of four requesters (round-robin with an aging override),
// latches its 32-bit packet and serialises it as four bytes. Optional macro: OUTPORT_PKTCNT_EN.
module outport_rr_arbiter #(
    parameter int         PORTID    = 0,
    parameter logic [3:0] AGE_LIMIT = 4'd6
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [3:0]       req,
    input  logic [3:0][31:0] req_data,
    output logic [3:0]       grant,
    input  logic             free_outbound,
    output logic             put_outbound,
    output logic [7:0]       payload_outbound,
    output logic             busy,
    output logic [15:0]      pkt_count
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_HOLD  = 3'd1;
    localparam logic [2:0] ST_SEND1 = 3'd2;
    localparam logic [2:0] ST_SEND2 = 3'd3;
    localparam logic [2:0] ST_SEND3 = 3'd4;

    // PORTID carries no logic; this block only records that it must be non-negative.
    if (PORTID < 0) begin : g_portid_invalid
    end

    logic [2:0]  state_reg;
    logic [2:0]  state_next;
    logic [31:0] data_reg;
    logic [1:0]  last_reg;
    logic        armed_reg;
    logic [3:0]  aged;
    logic        grant_ok;
    logic [1:0]  rr_idx;
    logic        rr_found;
    logic [1:0]  age_idx;
    logic [1:0]  cand;
    logic [1:0]  winner;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_wait
            logic [3:0] wait_reg;
            always_ff @(posedge clk or negedge rst_b) begin
                if (!rst_b) begin
                    wait_reg <= 4'd0;
                end else if (!req[gi] || grant[gi]) begin
                    wait_reg <= 4'd0;
                end else if (wait_reg != 4'hF) begin
                    wait_reg <= wait_reg + 4'd1;
                end
            end
            assign aged[gi] = req[gi] && (wait_reg >= AGE_LIMIT);
        end
    endgenerate

    // armed_reg holds grants off until the first clock edge after reset is released.
    assign grant_ok = armed_reg && (|req) &&
                      ((state_reg == ST_IDLE) || (state_reg == ST_SEND3));

    always_comb begin
        rr_idx   = 2'd0;
        rr_found = 1'b0;
        cand     = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_reg + 2'(k);
            if (!rr_found && req[cand]) begin
                rr_idx   = cand;
                rr_found = 1'b1;
            end
        end
        age_idx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (aged[k]) begin
                age_idx = 2'(k);
            end
        end
        winner = (|aged) ? age_idx : rr_idx;
    end

    assign grant = grant_ok ? (4'b0001 << winner) : 4'b0000;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (grant_ok) state_next = ST_HOLD;
            ST_HOLD:  if (free_outbound) state_next = ST_SEND1;
            ST_SEND1: state_next = ST_SEND2;
            ST_SEND2: state_next = ST_SEND3;
            ST_SEND3: state_next = grant_ok ? ST_HOLD : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_reg <= ST_IDLE;
            data_reg  <= 32'd0;
            last_reg  <= 2'd3;
            armed_reg <= 1'b0;
        end else begin
            armed_reg <= 1'b1;
            state_reg <= state_next;
            if (grant_ok) begin
                data_reg <= req_data[winner];
                last_reg <= winner;
            end
        end
    end

    always_comb begin
        payload_outbound = 8'h00;
        case (state_reg)
            ST_HOLD:  if (free_outbound) payload_outbound = data_reg[31:24];
            ST_SEND1: payload_outbound = data_reg[23:16];
            ST_SEND2: payload_outbound = data_reg[15:8];
            ST_SEND3: payload_outbound = data_reg[7:0];
            default:  payload_outbound = 8'h00;
        endcase
    end

    assign put_outbound = (state_reg == ST_HOLD) && free_outbound;
    assign busy         = (state_reg != ST_IDLE);

`ifdef OUTPORT_PKTCNT_EN
    logic [15:0] pkt_count_reg;
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            pkt_count_reg <= 16'd0;
        end else if (state_reg == ST_SEND3) begin
            pkt_count_reg <= pkt_count_reg + 16'd1;
        end
    end
    assign pkt_count = pkt_count_reg;
`else
    assign pkt_count = 16'd0;
`endif

endmodule

// File: tb/tb_outport_rr_arbiter.sv
// Directed bench for outport_rr_arbiter: single packet, backpressure, reset abort,
// packet counter, round-robin fairness and aging override.
module tb_outport_rr_arbiter;

    logic clk = 1'b0;
    logic rst_b;
    logic free;

    logic [3:0]       req0, req_rr, req_ag;
    logic [3:0][31:0] dat0, dat_rr, dat_ag;
    logic [3:0]       g0, g_rr, g_ag;
    logic             put0, put_rr, put_ag;
    logic [7:0]       pay0, pay_rr, pay_ag;
    logic             busy0, busy_rr, busy_ag;
    logic [15:0]      cnt0, cnt_rr, cnt_ag;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_cnt;

    always #5 clk = ~clk;

    outport_rr_arbiter dut (
        .clk(clk), .rst_b(rst_b), .req(req0), .req_data(dat0), .grant(g0),
        .free_outbound(free), .put_outbound(put0), .payload_outbound(pay0),
        .busy(busy0), .pkt_count(cnt0)
    );

    // Aging parked at its ceiling so four-way contention stays pure round-robin.
    outport_rr_arbiter #(.PORTID(1), .AGE_LIMIT(4'd15)) dut_rr (
        .clk(clk), .rst_b(rst_b), .req(req_rr), .req_data(dat_rr), .grant(g_rr),
        .free_outbound(free), .put_outbound(put_rr), .payload_outbound(pay_rr),
        .busy(busy_rr), .pkt_count(cnt_rr)
    );

    outport_rr_arbiter #(.PORTID(2), .AGE_LIMIT(4'd2)) dut_ag (
        .clk(clk), .rst_b(rst_b), .req(req_ag), .req_data(dat_ag), .grant(g_ag),
        .free_outbound(free), .put_outbound(put_ag), .payload_outbound(pay_ag),
        .busy(busy_ag), .pkt_count(cnt_ag)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end else begin
            $display("ok   %s: %h (t=%0t)", tag, got, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_b  = 1'b0;
        free   = 1'b1;
        req0   = 4'b0010;
        req_rr = 4'b0000;
        req_ag = 4'b0000;
        dat0   = '0;
        dat_rr = '0;
        dat_ag = '0;
        dat0[1] = 32'hA1B2C3D4;

        // Reset state, with a request already pending
        #3;
        check("rst_grant", 32'(g0), 32'h0);
        check("rst_busy", 32'(busy0), 32'h0);
        check("rst_put", 32'(put0), 32'h0);
        check("rst_payload", 32'(pay0), 32'h0);
        check("rst_cnt", 32'(cnt0), 32'h0);
        @(negedge clk);
        rst_b = 1'b1;
        #1;
        check("grant_before_edge", 32'(g0), 32'h0);

        // Single packet from requester 1
        tick;
        check("sp_grant", 32'(g0), 32'h2);
        check("sp_busy_idle", 32'(busy0), 32'h0);
        tick;
        req0 = 4'b0000;
        dat0[1] = 32'hDEADBEEF;
        #1;
        check("sp_put", 32'(put0), 32'h1);
        check("sp_byte0", 32'(pay0), 32'hA1);
        check("sp_grant_off", 32'(g0), 32'h0);
        check("sp_busy", 32'(busy0), 32'h1);
        tick;
        check("sp_put_s1", 32'(put0), 32'h0);
        check("sp_byte1", 32'(pay0), 32'hB2);
        tick;
        check("sp_byte2", 32'(pay0), 32'hC3);
        tick;
        check("sp_byte3", 32'(pay0), 32'hD4);
        tick;
        check("sp_done_busy", 32'(busy0), 32'h0);
        check("sp_done_put", 32'(put0), 32'h0);

        // Backpressure: 5 HOLD cycles, first byte appears when free rises
        free = 1'b0;
        req0 = 4'b0001;
        dat0[0] = 32'h11223344;
        #1;
        check("bp_grant", 32'(g0), 32'h1);
        tick;
        req0 = 4'b0000;
        #1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_hold%0d_put", i), 32'(put0), 32'h0);
            check($sformatf("bp_hold%0d_pay", i), 32'(pay0), 32'h0);
            check($sformatf("bp_hold%0d_busy", i), 32'(busy0), 32'h1);
            if (i < 4) tick;
        end
        tick;
        free = 1'b1;
        #1;
        check("bp_put", 32'(put0), 32'h1);
        check("bp_byte0", 32'(pay0), 32'h11);
        tick;
        free = 1'b0;
        #1;
        check("bp_byte1_nofree", 32'(pay0), 32'h22);
        tick;
        check("bp_byte2", 32'(pay0), 32'h33);
        tick;
        check("bp_byte3", 32'(pay0), 32'h44);
        tick;
        check("bp_done_busy", 32'(busy0), 32'h0);
        free = 1'b1;

        // Reset in SEND2 aborts the packet
        req0 = 4'b0100;
        dat0[2] = 32'h55667788;
        #1;
        check("ra_grant", 32'(g0), 32'h4);
        tick;
        req0 = 4'b0000;
        #1;
        check("ra_byte0", 32'(pay0), 32'h55);
        tick;
        check("ra_byte1", 32'(pay0), 32'h66);
        tick;
        check("ra_byte2", 32'(pay0), 32'h77);
        #2;
        rst_b = 1'b0;
        req0 = 4'b1000;
        #1;
        check("ra_put", 32'(put0), 32'h0);
        check("ra_payload", 32'(pay0), 32'h0);
        check("ra_busy", 32'(busy0), 32'h0);
        check("ra_grant_in_rst", 32'(g0), 32'h0);
        @(negedge clk);
        req0 = 4'b0000;
        rst_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            check($sformatf("ra_after%0d_put", i), 32'(put0), 32'h0);
            check($sformatf("ra_after%0d_pay", i), 32'(pay0), 32'h0);
            check($sformatf("ra_after%0d_busy", i), 32'(busy0), 32'h0);
        end

        // Three complete packets for the counter
        for (int k = 0; k < 3; k++) begin
            req0 = 4'b0001;
            dat0[0] = 32'hC0000000 | 32'(k);
            #1;
            check($sformatf("pc%0d_grant", k), 32'(g0), 32'h1);
            tick;
            req0 = 4'b0000;
            #1;
            check($sformatf("pc%0d_byte0", k), 32'(pay0), 32'hC0);
            tick;
            tick;
            tick;
            check($sformatf("pc%0d_byte3", k), 32'(pay0), 32'(k));
            tick;
`ifdef OUTPORT_PKTCNT_EN
            exp_cnt = 16'(k + 1);
`else
            exp_cnt = 16'd0;
`endif
            check($sformatf("pc%0d_count", k), 32'(cnt0), 32'(exp_cnt));
        end

        // Round-robin fairness: all four held, refilled on every grant
        req_rr = 4'b1111;
        for (int i = 0; i < 4; i++) dat_rr[i] = {4'hA, 4'(i), 24'h000000};
        #1;
        check("rr_grant0", 32'(g_rr), 32'h1);
        for (int n = 1; n <= 4; n++) begin
            tick;
            check($sformatf("rr_put%0d", n), 32'(put_rr), 32'h1);
            check($sformatf("rr_byte0_%0d", n), 32'(pay_rr), 32'hA0 + 32'((n - 1) % 4));
            tick;
            tick;
            tick;
            check($sformatf("rr_busy%0d", n), 32'(busy_rr), 32'h1);
            check($sformatf("rr_grant%0d", n), 32'(g_rr), 32'h1 << (n % 4));
        end
        tick;
        req_rr = 4'b0000;
        #1;
        check("rr_put5", 32'(put_rr), 32'h1);
        check("rr_byte0_5", 32'(pay_rr), 32'hA0);
        tick;
        tick;
        tick;
        tick;
        check("rr_done_busy", 32'(busy_rr), 32'h0);

        // Aging (limit 2): requester 3 overrides round-robin choice of 1
        req_ag = 4'b0001;
        dat_ag[0] = 32'h0F0F0F0F;
        dat_ag[1] = 32'h1E1E1E1E;
        dat_ag[3] = 32'h3C3C3C3C;
        #1;
        check("ag_grant0", 32'(g_ag), 32'h1);
        tick;
        req_ag = 4'b0000;
        tick;
        req_ag = 4'b1000;
        tick;
        tick;
        req_ag = 4'b1010;
        #1;
        check("ag_grant3", 32'(g_ag), 32'h8);
        tick;
        req_ag = 4'b0010;
        #1;
        check("ag_put3", 32'(put_ag), 32'h1);
        check("ag_byte0_3", 32'(pay_ag), 32'h3C);
        tick;
        tick;
        tick;
        check("ag_grant1", 32'(g_ag), 32'h2);
        tick;
        req_ag = 4'b0000;
        #1;
        check("ag_byte0_1", 32'(pay_ag), 32'h1E);
        tick;
        tick;
        tick;
        tick;
        check("ag_done_busy", 32'(busy_ag), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
